// File: rtl/psum_ofifo_pkg.sv
// Shared types and helpers for the psum output collector.
// Latency: none (declarations only); backpressure: n/a.
package psum_ofifo_pkg;

  localparam int PSUM_BW = 16;
  localparam int COL     = 8;

  typedef logic signed [PSUM_BW-1:0] psum_t;

  // Smallest r with 2**r >= value; sizes pointers from the FIFO depth.
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/psum_col_fifo.sv
// Single-column psum FIFO: writes land in the cycle after wr, dout shows the head combinationally.
// Backpressure: a write into a full FIFO is dropped and latches the sticky ovf flag.
module psum_col_fifo
  import psum_ofifo_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic [psum_bw-1:0] din,
  input  logic               rd,
  output logic [psum_bw-1:0] dout,
  output logic               empty,
  output logic               full,
  output logic               ovf
);

  localparam int AW = clog2_f(depth);
  localparam int CW = AW + 1;

  logic [psum_bw-1:0] mem_q [depth];
  logic [AW-1:0]      wptr_q, wptr_d;
  logic [AW-1:0]      rptr_q, rptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               do_wr, do_rd;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(depth));
  assign do_wr = wr & ~full;
  assign do_rd = rd & ~empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q | (wr & full);
    if (do_wr) wptr_d = wptr_q + AW'(1);
    if (do_rd) rptr_d = rptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage is deliberately left uncleared by reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (!reset && do_wr) mem_q[wptr_q] <= din;
  end

  assign dout = mem_q[rptr_q];
  assign ovf  = ovf_q;

endmodule

// File: rtl/psum_ofifo.sv
// Per-column psum collector below a mac_row; releases a full row once every column holds data.
// Popped row is registered (visible one cycle after rd); optional ReLU on pop under PSUM_RELU_EN.
module psum_ofifo
  import psum_ofifo_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = PSUM_BW,
  parameter int col     = COL,
  parameter int depth   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_ovf
);

  logic [col-1:0]              empty_w, full_w, ovf_w;
  logic [col-1:0][psum_bw-1:0] dout_w;
  logic [col-1:0][psum_bw-1:0] out_q, out_d;
  logic                        pop;

  // bw only travels with the array parameters; reject nonsensical builds at elaboration.
  if (bw < 1 || depth < 2 || (depth & (depth - 1)) != 0) begin : g_bad_param
    $error("psum_ofifo: bw must be positive and depth a power of two >= 2");
  end

  for (genvar i = 0; i < col; i++) begin : g_col
    psum_col_fifo #(
      .psum_bw (psum_bw),
      .depth   (depth)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (wr[i]),
      .din   (in[psum_bw*i +: psum_bw]),
      .rd    (pop),
      .dout  (dout_w[i]),
      .empty (empty_w[i]),
      .full  (full_w[i]),
      .ovf   (ovf_w[i])
    );
  end

  assign o_valid = ~|empty_w;
  assign o_full  = |full_w;
  assign o_ready = ~o_full;
  assign o_ovf   = |ovf_w;
  assign pop     = rd & o_valid;

  always_comb begin
    out_d = out_q;
    if (pop) begin
      for (int i = 0; i < col; i++) begin
        out_d[i] = dout_w[i];
`ifdef PSUM_RELU_EN
        if (dout_w[i][psum_bw-1]) out_d[i] = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) out_q <= '0;
    else       out_q <= out_d;
  end

  assign out = out_q;

endmodule

// File: tb/tb_psum_ofifo.sv
// Self-checking bench for psum_ofifo: per-column queue model feeding a row scoreboard,
// a skewed-fill vector table, and hand sequences for full/overflow, steady state, reset and ReLU.
`timescale 1ns/1ps
module tb_psum_ofifo;
  import psum_ofifo_pkg::*;

  localparam int NC = 8;
  localparam int W  = 16;
  localparam int D  = 64;
  localparam logic [W*NC-1:0] ROW_SKEW =
    128'h0107_0106_0105_0104_0103_0102_0101_0100;

  logic            clk = 1'b0;
  logic            reset;
  logic [W*NC-1:0] in_v;
  logic [NC-1:0]   wr_v;
  logic            rd_v;
  logic [W*NC-1:0] out_v;
  logic            o_valid, o_full, o_ready, o_ovf;

  psum_ofifo #(.bw(4), .psum_bw(W), .col(NC), .depth(D)) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (in_v),
    .wr      (wr_v),
    .rd      (rd_v),
    .out     (out_v),
    .o_valid (o_valid),
    .o_full  (o_full),
    .o_ready (o_ready),
    .o_ovf   (o_ovf)
  );

  always #5 clk = ~clk;

  psum_t           mq [NC][$];
  logic [W*NC-1:0] sb [$];
  logic [W*NC-1:0] out_m;
  logic            ovf_m;
  int              n_vec = 0;
  int              n_err = 0;

  typedef struct {
    logic [NC-1:0]   wr;
    logic            rd;
    logic            exp_valid;
    logic [W*NC-1:0] exp_out;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string name, input logic [W*NC-1:0] act,
                       input logic [W*NC-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic m_valid();
    for (int i = 0; i < NC; i++) if (mq[i].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_full();
    for (int i = 0; i < NC; i++) if (mq[i].size() == D) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W*NC-1:0] mk_row(input int k);
    logic [W*NC-1:0] r;
    r = '0;
    for (int i = 0; i < NC; i++) r[i*W +: W] = 16'(k * 16 + i);
    return r;
  endfunction

  // One clock: update the model with pre-edge state, drive, clock, then compare everything.
  task automatic step(input logic rst, input logic [NC-1:0] w,
                      input logic [W*NC-1:0] d, input logic r);
    logic [NC-1:0]   full_pre;
    logic            pop;
    logic [W*NC-1:0] row;
    psum_t           v;
    reset = rst;
    wr_v  = w;
    in_v  = d;
    rd_v  = r;
    row   = '0;
    if (rst) begin
      for (int i = 0; i < NC; i++) mq[i].delete();
      sb.delete();
      ovf_m = 1'b0;
      out_m = '0;
    end else begin
      for (int i = 0; i < NC; i++) full_pre[i] = (mq[i].size() == D);
      pop = r && m_valid();
      if (pop) begin
        for (int i = 0; i < NC; i++) begin
          v = mq[i].pop_front();
`ifdef PSUM_RELU_EN
          if (v < 0) v = '0;
`endif
          row[i*W +: W] = v;
        end
        sb.push_back(row);
      end
      for (int i = 0; i < NC; i++) begin
        if (w[i]) begin
          if (full_pre[i]) ovf_m = 1'b1;
          else mq[i].push_back(psum_t'(d[i*W +: W]));
        end
      end
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) out_m = sb.pop_front();
    check("out", out_v, out_m);
    check("o_valid", {127'b0, o_valid}, {127'b0, m_valid()});
    check("o_full", {127'b0, o_full}, {127'b0, m_full()});
    check("o_ready", {127'b0, o_ready}, {127'b0, ~m_full()});
    check("o_ovf", {127'b0, o_ovf}, {127'b0, ovf_m});
  endtask

  initial begin
    logic [W*NC-1:0] prev, cur, ra, rb, rr;
    reset = 1'b1;
    wr_v  = '0;
    in_v  = '0;
    rd_v  = 1'b0;
    out_m = '0;
    ovf_m = 1'b0;

    // Reset state, then a read of an empty collector.
    step(1'b1, '0, '0, 1'b0);
    step(1'b1, '0, '0, 1'b0);
    check("rst_out", out_v, '0);
    check("rst_ready", {127'b0, o_ready}, 128'd1);
    step(1'b0, '0, '0, 1'b1);
    check("rd_empty_out", out_v, '0);

    // Skewed fill table.
    for (int k = 0; k < 8; k++)
      tbl[k] = '{wr: 8'((1 << (k + 1)) - 1), rd: 1'b0, exp_valid: (k == 7), exp_out: '0};
    tbl[8] = '{wr: 8'h00, rd: 1'b1, exp_valid: 1'b0, exp_out: ROW_SKEW};
    for (int k = 0; k < 9; k++) begin
      step(1'b0, tbl[k].wr, ROW_SKEW, tbl[k].rd);
      check("skew_valid", {127'b0, o_valid}, {127'b0, tbl[k].exp_valid});
      check("skew_out", out_v, tbl[k].exp_out);
    end

    // Fill to full, overflow, drain with wrap.
    step(1'b1, '0, '0, 1'b0);
    for (int k = 0; k < D; k++) begin
      step(1'b0, '1, mk_row(k), 1'b0);
      if (k == D - 2) check("full_63", {127'b0, o_full}, 128'd0);
    end
    check("full_64", {127'b0, o_full}, 128'd1);
    check("ready_64", {127'b0, o_ready}, 128'd0);
    step(1'b0, '1, {NC{16'hDEAD}}, 1'b0);
    check("ovf_65", {127'b0, o_ovf}, 128'd1);
    for (int k = 0; k < D; k++) begin
      step(1'b0, '0, '0, 1'b1);
      check("drain_out", out_v, mk_row(k));
    end
    check("drain_empty", {127'b0, o_valid}, 128'd0);
    step(1'b0, '0, '0, 1'b1);
    check("drain_extra_rd", out_v, mk_row(D - 1));

    // Steady state: one entry per column, write and pop every cycle.
    prev = mk_row(200);
    step(1'b0, '1, prev, 1'b0);
    for (int j = 0; j < 20; j++) begin
      cur = mk_row(300 + j * 7);
      step(1'b0, '1, cur, 1'b1);
      check("steady_valid", {127'b0, o_valid}, 128'd1);
      check("steady_out", out_v, prev);
      prev = cur;
    end

    // Reset with data queued and a wr/rd in the reset cycle.
    for (int k = 0; k < 10; k++) step(1'b0, '1, mk_row(500 + k), 1'b0);
    step(1'b1, '1, mk_row(999), 1'b1);
    check("mrst_valid", {127'b0, o_valid}, 128'd0);
    check("mrst_out", out_v, '0);
    check("mrst_ovf", {127'b0, o_ovf}, 128'd0);
    ra = mk_row(700);
    rb = mk_row(701);
    step(1'b0, '1, ra, 1'b0);
    step(1'b0, '1, rb, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    check("mrst_first", out_v, ra);
    step(1'b0, '0, '0, 1'b1);
    check("mrst_second", out_v, rb);

    // Negative and positive psums through the pop path.
    rr = mk_row(40);
    rr[3*W +: W] = 16'hFFF0;
    rr[4*W +: W] = 16'h0010;
    step(1'b0, '1, rr, 1'b0);
    step(1'b0, '0, '0, 1'b1);
`ifdef PSUM_RELU_EN
    check("relu_col3", {112'b0, out_v[3*W +: W]}, 128'h0);
`else
    check("relu_col3", {112'b0, out_v[3*W +: W]}, 128'hFFF0);
`endif
    check("relu_col4", {112'b0, out_v[4*W +: W]}, 128'h0010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
